w0rm_peripheral_bus_combiner: RTL and testbench
===============================================

Name: w0rm_peripheral_bus_combiner

Overview:
N-port successor to the two-port peripheral bus extender. Merges read/write responses from NUM_PORTS memory-mapped devices (core RAM, GPIO, timers, ...) onto the single W0RM core response channel. Tracks the one outstanding core request and resolves collisions by fixed priority. Generates a bus-error response when no device answers within TIMEOUT cycles. Sits between the W0RM_TopLevel mem_* interface and the peripheral return paths.

Parameters:
NUM_PORTS, 4, number of device response ports (2..16); port 0 is highest priority
DATA_WIDTH, 32, data width
ADDR_WIDTH, 32, address width
TIMEOUT, 16, cycles to wait for a response before erroring; 0 disables the timeout
ERROR_DATA, 32'hDEAD_BEEF, bus_data_o value on an error response (truncated to DATA_WIDTH)
WRITE_ACK, 1, 1: writes wait for a response like reads; 0: writes complete without tracking

Ports:
core_clk  in  1  core clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
req_valid_i  in  1  core request strobe (core mem_valid_o)
req_read_i  in  1  request is a read
req_write_i  in  1  request is a write
req_addr_i  in  ADDR_WIDTH  request address
port_valid_i  in  NUM_PORTS  per-device response valid; bit k = port k
port_data_i  in  NUM_PORTS*DATA_WIDTH  per-device data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
bus_valid_o  out  1  response to core, one-cycle pulse
bus_data_o  out  DATA_WIDTH  response data
bus_error_o  out  1  qualifies bus_valid_o: response is a timeout error
collision_o  out  1  pulse with bus_valid_o: more than one port was valid
spurious_o  out  1  pulse: a response arrived with no request outstanding
pending_o  out  1  a request is outstanding
err_addr_o  out  ADDR_WIDTH  address of the most recent timed-out request
err_count_o  out  8  timeout count, saturates at 255

Behaviour:
- Reset (async assert; release synchronised to core_clk): state IDLE. All outputs 0. Wait counter 0.
- Tracked request: req_valid_i && (req_read_i || (req_write_i && WRITE_ACK)). Other strobes are ignored and change no state.
- States: IDLE and WAIT.
  - IDLE + tracked request -> WAIT. Latch req_addr_i. Clear the wait counter.
  - WAIT + any port_valid_i -> deliver the response. If a tracked request arrives in the same cycle, stay in WAIT, relatch the address and clear the counter; otherwise go to IDLE.
  - WAIT, no response, counter == TIMEOUT-1 (TIMEOUT != 0) -> deliver an error response and go to IDLE. Otherwise increment the counter.
  - WAIT + tracked request without a response: protocol violation. The new request is ignored and the original stays outstanding.
- Response is registered: port_valid_i seen at edge n gives bus_valid_o=1 for the cycle after edge n.
  - bus_data_o = data of the lowest-index valid port.
  - collision_o = 1 if popcount(port_valid_i) > 1.
  - bus_error_o = 0.
- Error response, for one cycle:
  - bus_valid_o=1, bus_error_o=1, bus_data_o=ERROR_DATA.
  - err_addr_o <= latched address.
  - err_count_o increments, saturating at 255.
  - Error latency: TIMEOUT cycles after request acceptance, plus 1 register stage.
- Response and timeout in the same cycle: the response wins; no error is raised.
- Response while IDLE: not forwarded (bus_valid_o stays 0). spurious_o pulses one cycle, registered.
- bus_data_o holds its last value when bus_valid_o=0.
- pending_o = (state == WAIT), registered.
- TIMEOUT=0: WAIT persists until a response arrives.

Test Plan:
- Read at 0x80000080, port 1 answers 0x000000A5 three cycles later -> one cycle later bus_valid_o=1, bus_data_o=0x000000A5, bus_error_o=0, pending_o 1->0.
- Ports 0 and 2 valid together with 0x11111111 and 0x22222222 -> bus_data_o=0x11111111, collision_o=1 for one cycle.
- Read at 0x00001234, no response, TIMEOUT=16 -> 17 cycles after the request: bus_valid_o=1, bus_error_o=1, bus_data_o=0xDEADBEEF, err_addr_o=0x00001234, err_count_o=1. A 256th timeout leaves err_count_o=255.
- Response on the cycle the counter hits 15 -> normal response delivered; err_count_o unchanged.
- Port 3 valid in IDLE -> spurious_o pulses, bus_valid_o stays 0. Back-to-back: response plus new read in the same cycle -> pending_o stays 1, second response delivered normally.
- reset_n low during WAIT -> all outputs 0 immediately (asynchronous). After release, the late device response produces only spurious_o. WRITE_ACK=0 write -> pending_o stays 0.

Source files
------------

// File: rtl/w0rm_peripheral_bus_combiner.sv
// N-port response combiner for the W0RM core memory channel.
// Fixed-priority merge, single outstanding request, timeout bus errors.
module w0rm_peripheral_bus_combiner #(
   parameter int          NUM_PORTS  = 4,
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          TIMEOUT    = 16,
   parameter logic [31:0] ERROR_DATA = 32'hDEAD_BEEF,
   parameter bit          WRITE_ACK  = 1'b1
) (
   input  logic                            core_clk,
   input  logic                            reset_n,
   input  logic                            req_valid_i,
   input  logic                            req_read_i,
   input  logic                            req_write_i,
   input  logic [ADDR_WIDTH-1:0]           req_addr_i,
   input  logic [NUM_PORTS-1:0]            port_valid_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i,
   output logic                            bus_valid_o,
   output logic [DATA_WIDTH-1:0]           bus_data_o,
   output logic                            bus_error_o,
   output logic                            collision_o,
   output logic                            spurious_o,
   output logic                            pending_o,
   output logic [ADDR_WIDTH-1:0]           err_addr_o,
   output logic [7:0]                      err_count_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_bus_valid;
   logic [DATA_WIDTH-1:0] r_bus_data;
   logic                  r_bus_error;
   logic                  r_collision;
   logic                  r_spurious;
   logic [ADDR_WIDTH-1:0] r_err_addr;
   logic [7:0]            r_err_count;

   logic                  w_tracked;
   logic                  w_any;
   logic                  w_multi;
   logic                  w_hit_to;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_deliver;
   logic                  w_error;
   logic                  w_spur;
   logic                  w_accept;
   logic                  w_cnt_inc;

   // Reset asserts immediately, releases two edges later.
   always_ff @(posedge core_clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   assign w_tracked = req_valid_i &&
                      (req_read_i || (req_write_i && WRITE_ACK));
   assign w_any     = |port_valid_i;
   assign w_multi   = |(port_valid_i & (port_valid_i - NUM_PORTS'(1)));
   assign w_hit_to  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

   // Lowest-index valid port wins.
   always_comb begin
      w_sel_data = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (port_valid_i[k])
            w_sel_data = port_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge core_clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_tracked) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_any)         w_next = w_tracked ? S_WAIT : S_IDLE;
            else if (w_hit_to) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_deliver = 1'b0;
      w_error   = 1'b0;
      w_spur    = 1'b0;
      w_accept  = 1'b0;
      w_cnt_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_spur   = w_any;
            w_accept = w_tracked;
         end
         S_WAIT: begin
            w_deliver = w_any;
            w_error   = !w_any && w_hit_to;
            w_accept  = w_any && w_tracked;
            w_cnt_inc = !w_any && !w_hit_to && (TIMEOUT != 0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge core_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_bus_valid <= 1'b0;
         r_bus_data  <= '0;
         r_bus_error <= 1'b0;
         r_collision <= 1'b0;
         r_spurious  <= 1'b0;
         r_err_addr  <= '0;
         r_err_count <= '0;
      end else begin
         r_bus_valid <= w_deliver || w_error;
         r_bus_error <= w_error;
         r_collision <= w_deliver && w_multi;
         r_spurious  <= w_spur;
         if (w_accept) begin
            r_addr <= req_addr_i;
            r_cnt  <= '0;
         end else if (w_cnt_inc) begin
            r_cnt  <= r_cnt + CW'(1);
         end
         if (w_deliver)    r_bus_data <= w_sel_data;
         else if (w_error) r_bus_data <= DATA_WIDTH'(ERROR_DATA);
         if (w_error) begin
            r_err_addr <= r_addr;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign bus_valid_o = r_bus_valid;
   assign bus_data_o  = r_bus_data;
   assign bus_error_o = r_bus_error;
   assign collision_o = r_collision;
   assign spurious_o  = r_spurious;
   assign pending_o   = (r_state == S_WAIT);
   assign err_addr_o  = r_err_addr;
   assign err_count_o = r_err_count;

endmodule

// File: tb/tb_w0rm_peripheral_bus_combiner.sv
// Scoreboard bench for the peripheral bus combiner.
// Second instance exercises untracked writes.
module tb_w0rm_peripheral_bus_combiner;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic             core_clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_read = 1'b0;
   logic             req_write = 1'b0;
   logic [AW-1:0]    req_addr = '0;
   logic [NP-1:0]    port_valid = '0;
   logic [NP*DW-1:0] port_data = '0;

   logic          bus_valid_o, bus_error_o, collision_o;
   logic          spurious_o, pending_o;
   logic [DW-1:0] bus_data_o;
   logic [AW-1:0] err_addr_o;
   logic [7:0]    err_count_o;

   logic          bv2, be2, col2, sp2, pend2;
   logic [DW-1:0] bd2;
   logic [AW-1:0] ea2;
   logic [7:0]    ec2;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic        col;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   resp_seen = 0;

   always #5 core_clk = ~core_clk;

   w0rm_peripheral_bus_combiner #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .TIMEOUT(16), .ERROR_DATA(32'hDEAD_BEEF), .WRITE_ACK(1'b1)
   ) dut (
      .core_clk(core_clk), .reset_n(reset_n),
      .req_valid_i(req_valid), .req_read_i(req_read),
      .req_write_i(req_write), .req_addr_i(req_addr),
      .port_valid_i(port_valid), .port_data_i(port_data),
      .bus_valid_o(bus_valid_o), .bus_data_o(bus_data_o),
      .bus_error_o(bus_error_o), .collision_o(collision_o),
      .spurious_o(spurious_o), .pending_o(pending_o),
      .err_addr_o(err_addr_o), .err_count_o(err_count_o)
   );

   w0rm_peripheral_bus_combiner #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .TIMEOUT(16), .ERROR_DATA(32'hDEAD_BEEF), .WRITE_ACK(1'b0)
   ) dut_nowack (
      .core_clk(core_clk), .reset_n(reset_n),
      .req_valid_i(req_valid), .req_read_i(req_read),
      .req_write_i(req_write), .req_addr_i(req_addr),
      .port_valid_i(port_valid), .port_data_i(port_data),
      .bus_valid_o(bv2), .bus_data_o(bd2),
      .bus_error_o(be2), .collision_o(col2),
      .spurious_o(sp2), .pending_o(pend2),
      .err_addr_o(ea2), .err_count_o(ec2)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      exp_t e;
      @(posedge core_clk);
      #1;
      if (bus_valid_o) begin
         resp_seen++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp data %h err %b", bus_data_o,
                     bus_error_o);
         end else begin
            e = sb.pop_front();
            if ({bus_data_o, bus_error_o, collision_o} !==
                {e.data, e.err, e.col}) begin
               errors++;
               $display("FAIL resp got %h/%b/%b want %h/%b/%b",
                        bus_data_o, bus_error_o, collision_o,
                        e.data, e.err, e.col);
            end
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [31:0] d, input logic er,
                       input logic c);
      exp_t e;
      e.data = d;
      e.err  = er;
      e.col  = c;
      sb.push_back(e);
   endtask

   task automatic set_port(input int k, input logic [31:0] d);
      port_valid[k] = 1'b1;
      port_data[k*DW +: DW] = d;
   endtask

   task automatic issue_read(input logic [31:0] a);
      req_valid = 1'b1;
      req_read  = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
   endtask

   task automatic clear_req();
      req_valid = 1'b0;
      req_read  = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ticks(2);
      checks++;
      if ({bus_valid_o, bus_data_o, bus_error_o, collision_o, spurious_o,
           pending_o, err_addr_o, err_count_o} !== '0) begin
         errors++;
         $display("FAIL reset_state valid %b data %h pend %b cnt %0d",
                  bus_valid_o, bus_data_o, pending_o, err_count_o);
      end
      reset_n = 1'b1;
      ticks(3);
   endtask

   task automatic test_read();
      int seen;
      issue_read(32'h8000_0080);
      tick();
      clear_req();
      checks++;
      if (pending_o !== 1'b1) begin
         errors++;
         $display("FAIL read_pending got %b want 1", pending_o);
      end
      ticks(2);
      seen = resp_seen;
      set_port(1, 32'h0000_00A5);
      push(32'h0000_00A5, 1'b0, 1'b0);
      tick();
      port_valid = '0;
      checks++;
      if (resp_seen != seen + 1 || pending_o !== 1'b0) begin
         errors++;
         $display("FAIL read_done seen %0d want %0d pend %b want 0",
                  resp_seen, seen + 1, pending_o);
      end
      tick();
      checks++;
      if (bus_valid_o !== 1'b0 || bus_data_o !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL data_hold got %b/%h want 0/000000a5",
                  bus_valid_o, bus_data_o);
      end
   endtask

   task automatic test_collision();
      issue_read(32'h8000_0100);
      tick();
      clear_req();
      set_port(0, 32'h1111_1111);
      set_port(2, 32'h2222_2222);
      push(32'h1111_1111, 1'b0, 1'b1);
      tick();
      port_valid = '0;
      tick();
      checks++;
      if (collision_o !== 1'b0) begin
         errors++;
         $display("FAIL collision_pulse got %b want 0", collision_o);
      end
   endtask

   task automatic test_timeout();
      issue_read(32'h0000_1234);
      tick();
      clear_req();
      ticks(15);
      checks++;
      if (bus_valid_o !== 1'b0 || pending_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early valid %b pend %b want 0/1",
                  bus_valid_o, pending_o);
      end
      push(32'hDEAD_BEEF, 1'b1, 1'b0);
      tick();
      checks++;
      if (err_addr_o !== 32'h0000_1234 || err_count_o !== 8'd1 ||
          pending_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_regs addr %h cnt %0d pend %b want 1234/1/0",
                  err_addr_o, err_count_o, pending_o);
      end
   endtask

   task automatic test_race();
      issue_read(32'h0000_2000);
      tick();
      clear_req();
      ticks(15);
      set_port(2, 32'h5A5A_5A5A);
      push(32'h5A5A_5A5A, 1'b0, 1'b0);
      tick();
      port_valid = '0;
      checks++;
      if (err_count_o !== 8'd1 || err_addr_o !== 32'h0000_1234) begin
         errors++;
         $display("FAIL race_errregs cnt %0d addr %h want 1/1234",
                  err_count_o, err_addr_o);
      end
   endtask

   task automatic test_spurious();
      set_port(3, 32'h3333_3333);
      tick();
      port_valid = '0;
      checks++;
      if (spurious_o !== 1'b1 || bus_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL spurious got %b/%b want 1/0", spurious_o,
                  bus_valid_o);
      end
      tick();
      checks++;
      if (spurious_o !== 1'b0) begin
         errors++;
         $display("FAIL spurious_pulse got %b want 0", spurious_o);
      end
   endtask

   task automatic test_back_to_back();
      issue_read(32'h0000_0A00);
      tick();
      clear_req();
      tick();
      set_port(0, 32'h0000_00A1);
      issue_read(32'h0000_0B00);
      push(32'h0000_00A1, 1'b0, 1'b0);
      tick();
      port_valid = '0;
      clear_req();
      checks++;
      if (pending_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pending got %b want 1", pending_o);
      end
      tick();
      set_port(1, 32'h0000_00B2);
      push(32'h0000_00B2, 1'b0, 1'b0);
      tick();
      port_valid = '0;
      checks++;
      if (pending_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done got %b want 0", pending_o);
      end
   endtask

   task automatic test_write();
      req_valid = 1'b1;
      req_read  = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0000_0C00;
      tick();
      clear_req();
      checks++;
      if (pending_o !== 1'b0) begin
         errors++;
         $display("FAIL null_strobe pend %b want 0", pending_o);
      end
      req_valid = 1'b1;
      req_write = 1'b1;
      tick();
      clear_req();
      checks++;
      if (pending_o !== 1'b1 || pend2 !== 1'b0) begin
         errors++;
         $display("FAIL write_track ack %b want 1 noack %b want 0",
                  pending_o, pend2);
      end
      set_port(0, 32'h0000_0077);
      push(32'h0000_0077, 1'b0, 1'b0);
      tick();
      port_valid = '0;
      tick();
   endtask

   task automatic test_saturate();
      for (int i = 2; i <= 256; i++) begin
         issue_read(32'h0001_0000 + i);
         tick();
         clear_req();
         push(32'hDEAD_BEEF, 1'b1, 1'b0);
         ticks(16);
      end
      checks++;
      if (err_count_o !== 8'd255 || err_addr_o !== 32'h0001_0100) begin
         errors++;
         $display("FAIL saturate cnt %0d addr %h want 255/00010100",
                  err_count_o, err_addr_o);
      end
   endtask

   task automatic test_async_reset();
      issue_read(32'h0000_0D00);
      tick();
      clear_req();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus_valid_o, bus_data_o, bus_error_o, collision_o, spurious_o,
           pending_o, err_addr_o, err_count_o} !== '0) begin
         errors++;
         $display("FAIL async_reset pend %b data %h cnt %0d addr %h",
                  pending_o, bus_data_o, err_count_o, err_addr_o);
      end
      ticks(2);
      reset_n = 1'b1;
      ticks(3);
      set_port(2, 32'h0000_0DDD);
      tick();
      port_valid = '0;
      checks++;
      if (spurious_o !== 1'b1 || bus_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL late_resp spur %b valid %b want 1/0",
                  spurious_o, bus_valid_o);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_collision();
      test_timeout();
      test_race();
      test_spurious();
      test_back_to_back();
      test_write();
      test_saturate();
      test_async_reset();
      ticks(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
